// File: rtl/rc_subtractor_serial.sv
// ---------------------------------------------------------------------------
// rc_subtractor_serial
//
// Bit-serial ripple-borrow subtractor. Computes A - B - Bor_in one bit per
// clock, LSB first, with a single full-subtractor cell and a borrow
// flip-flop.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request; only sampled in IDLE or DONE
//   A, B         in   minuend / subtrahend, captured on an accepted start
//   Bor_in       in   borrow in, captured on an accepted start
//   Diff_out     out  (A - B - Bor_in) mod 2^WIDTH, updated only on completion
//   Bor_out      out  final borrow (1 when A < B + Bor_in)
//   busy         out  high while bits are being processed (SHIFT)
//   done         out  one-cycle pulse when Diff_out/Bor_out become valid
//   state_dbg_o  out  current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
//
// Handshake: a start seen at a clock edge while the block is in IDLE or DONE
// is accepted on that edge; busy is high for exactly WIDTH cycles afterwards,
// then done is high for exactly one cycle. start is ignored while busy. A
// start seen during the done cycle is accepted immediately (back-to-back).
// ---------------------------------------------------------------------------
module rc_subtractor_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bor_in,
    output logic [WIDTH-1:0] Diff_out,
    output logic             Bor_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bor_out_q, bor_out_d;

    // Full-subtractor cell on the current LSBs.
    logic d_bit;
    logic bor_nxt;
    logic [WIDTH-1:0] res_shifted;

    assign d_bit       = a_q[0] ^ b_q[0] ^ bor_q;
    assign bor_nxt     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
    // Difference bits enter at the MSB so that after WIDTH shifts bit 0 of
    // the operands lands in bit 0 of the result.
    assign res_shifted = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        bor_d     = bor_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        bor_out_d = bor_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    bor_d   = Bor_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bor_d = bor_nxt;
                res_d = res_shifted;
                cnt_d = cnt_q + CW'(1);
                // Visible outputs change only here, so they never show a
                // partially built result.
                if (cnt_q == LAST_BIT) begin
                    diff_d    = res_shifted;
                    bor_out_d = bor_nxt;
                    state_d   = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            bor_q     <= 1'b0;
            cnt_q     <= '0;
            diff_q    <= '0;
            bor_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            bor_q     <= bor_d;
            cnt_q     <= cnt_d;
            diff_q    <= diff_d;
            bor_out_q <= bor_out_d;
        end
    end

    // Decoded straight from the state register: busy and done are mutually
    // exclusive by construction.
    assign busy        = (state_q == S_SHIFT);
    assign done        = (state_q == S_DONE);
    assign Diff_out    = diff_q;
    assign Bor_out     = bor_out_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rc_subtractor_serial.sv
module tb_rc_subtractor_serial;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       s4 = 1'b0, bi4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] d4;
    logic       bo4, busy4, done4;
    logic [1:0] st4;

    logic       s8 = 1'b0, bi8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] d8;
    logic       bo8, busy8, done8;
    logic [1:0] st8;

    rc_subtractor_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4), .Bor_in(bi4),
        .Diff_out(d4), .Bor_out(bo4), .busy(busy4), .done(done4),
        .state_dbg_o(st4)
    );

    rc_subtractor_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8), .Bor_in(bi8),
        .Diff_out(d8), .Bor_out(bo8), .busy(busy8), .done(done8),
        .state_dbg_o(st8)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];   // {bor, diff[7:0]}

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, wrap the difference, borrow when
    // the minuend is smaller than subtrahend plus borrow-in.
    function automatic logic [8:0] ref_sub(input int w, input int a, input int b, input int bi);
        int m;
        int r;
        logic [8:0] res;
        m = 1 << w;
        r = ((a - b - bi) % m + m) % m;
        res[7:0] = 8'(r);
        res[8] = (a < b + bi);
        return res;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit w8, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic bi);
        if (w8) begin
            s8 = st; a8 = a; b8 = b; bi8 = bi;
        end else begin
            s4 = st; a4 = a[3:0]; b4 = b[3:0]; bi4 = bi;
        end
    endtask

    // One operation. Called right after a falling edge. extra>0 keeps start
    // asserted (with A=B=1) for that many edges while the op is in progress.
    task automatic op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                      input logic bi, input int extra, input string nm);
        int w, lat, busy_cnt, done_cnt;
        bit hold_ok, excl_ok;
        logic [7:0] prev_d, got_d, cur_d;
        logic prev_b, got_b, cur_b, cur_busy, cur_done;
        logic [8:0] exp;
        w = w8 ? 8 : 4;
        lat = -1; busy_cnt = 0; done_cnt = 0;
        hold_ok = 1'b1; excl_ok = 1'b1;
        got_d = '0; got_b = 1'b0;
        exp_q.push_back(ref_sub(w, int'(a), int'(b), int'(bi)));
        prev_d = w8 ? d8 : {4'h0, d4};
        prev_b = w8 ? bo8 : bo4;
        drive(w8, 1'b1, a, b, bi);
        @(posedge clk);
        for (int i = 0; i <= w + 3; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            cur_d    = w8 ? d8 : {4'h0, d4};
            cur_b    = w8 ? bo8 : bo4;
            cur_busy = w8 ? busy8 : busy4;
            cur_done = w8 ? done8 : done4;
            if (cur_busy) busy_cnt++;
            if (cur_busy && cur_done) excl_ok = 1'b0;
            if (cur_done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = i; got_d = cur_d; got_b = cur_b;
                end
            end else if (lat < 0 && (cur_d !== prev_d || cur_b !== prev_b)) begin
                hold_ok = 1'b0;
            end
            if (i < extra) drive(w8, 1'b1, 8'd1, 8'd1, 1'b0);
            else drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        exp = exp_q.pop_front();
        chk({nm, " diff"}, 32'(got_d), 32'(exp[7:0]));
        chk({nm, " bor"}, 32'(got_b), 32'(exp[8]));
        chk({nm, " latency"}, 32'(lat), 32'(w));
        chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(w));
        chk({nm, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({nm, " outputs_held"}, 32'(hold_ok), 32'd1);
        chk({nm, " busy_done_excl"}, 32'(excl_ok), 32'd1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bi;
        logic [3:0] exp_diff;
        logic       exp_bor;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        vecs[1] = '{4'd5,  4'd7,  1'b1, 4'd13, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd11, 4'd10, 1'b0, 4'd1,  1'b0};
        vecs[5] = '{4'd14, 4'd1,  1'b1, 4'd12, 1'b0};

        // Reset state
        #1;
        chk("reset diff4", 32'(d4), 32'd0);
        chk("reset bor4", 32'(bo4), 32'd0);
        chk("reset busy4", 32'(busy4), 32'd0);
        chk("reset done4", 32'(done4), 32'd0);
        chk("reset state4", 32'(st4), 32'd0);
        chk("reset diff8", 32'(d8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven: DUT output compared against the hand-written table
        // directly, independent of the reference model.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, vecs[i].bi);
            @(posedge clk);
            @(negedge clk);
            drive(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            lat = -1;
            for (int c = 1; c <= 8 && lat < 0; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (done4) lat = c;
            end
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d diff", i), 32'(d4), 32'(vecs[i].exp_diff));
            chk($sformatf("vec%0d bor", i), 32'(bo4), 32'(vecs[i].exp_bor));
            repeat (2) @(negedge clk);
        end

        // Full handshake check via op task
        op(1'b0, 8'd9, 8'd3, 1'b0, 0, "op_9_3");

        // start re-pulsed while shifting with different operands
        op(1'b0, 8'd8, 8'd2, 1'b0, 2, "start_in_shift");

        // Back-to-back: start during the done cycle
        drive(1'b0, 1'b1, 8'd3, 8'd1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("b2b first done", 32'(done4), 32'd1);
        chk("b2b first diff", 32'(d4), 32'd2);
        drive(1'b0, 1'b1, 8'd14, 8'd1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b busy rise", 32'(busy4), 32'd1);
        chk("b2b done low", 32'(done4), 32'd0);
        drive(1'b0, 1'b0, 8'd7, 8'd7, 1'b0);
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4) lat = c;
        end
        chk("b2b second latency", 32'(lat), 32'd4);
        chk("b2b second diff", 32'(d4), 32'd12);
        chk("b2b second bor", 32'(bo4), 32'd0);
        repeat (2) @(negedge clk);

        // Reset mid-operation
        drive(1'b0, 1'b1, 8'd9, 8'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst diff", 32'(d4), 32'd0);
        chk("midrst bor", 32'(bo4), 32'd0);
        chk("midrst busy", 32'(busy4), 32'd0);
        chk("midrst done", 32'(done4), 32'd0);
        chk("midrst state", 32'(st4), 32'd0);
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done4 || busy4) lat++;
        end
        chk("midrst quiet", 32'(lat), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        op(1'b0, 8'd11, 8'd10, 1'b0, 0, "after_reset");

        // WIDTH=8 instance
        op(1'b1, 8'd200, 8'd100, 1'b1, 0, "w8_200_100");
        for (int i = 0; i < 40; i++)
            op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)), 0, "w8_rand");

        // Exhaustive 4-bit sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    op(1'b0, 8'(a), 8'(b), 1'(bi), 0, $sformatf("sweep_%0d_%0d_%0d", a, b, bi));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rc_subtractor_serial.md
Name: rc_subtractor_serial

Overview:
- Bit-serial ripple-borrow subtractor; the inverse-direction companion to the 4-bit ripple carry adder.
- Computes A - B - Bor_in one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Used where area matters more than latency; start/done handshake lets a controller or bench sequence operations.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
A  input  WIDTH  minuend, captured on accepted start
B  input  WIDTH  subtrahend, captured on accepted start
Bor_in  input  1  borrow in, captured on accepted start
Diff_out  output  WIDTH  difference (A - B - Bor_in) mod 2^WIDTH
Bor_out  output  1  final borrow; 1 when A < B + Bor_in
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when Diff_out/Bor_out become valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Diff_out=0, Bor_out=0, busy=0, done=0; internal shift regs, borrow FF, bit counter cleared. Takes effect immediately, including mid-operation; the aborted result is discarded and no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge -> capture A, B into shift regs, Bor_in into borrow FF, counter=0, busy=1, go SHIFT.
- SHIFT: each edge computes bit d = a0 ^ b0 ^ bor and next bor = (~a0 & b0) | (~(a0 ^ b0) & bor). d shifts into result reg MSB side (LSB-first fill). Operand regs shift right, counter increments.
- Counter width is $clog2(WIDTH+1). On the edge processing bit WIDTH-1: go DONE, busy=0, done=1.
- On that same edge Diff_out and Bor_out update from the completed result.
- start is ignored in SHIFT; operands are not re-captured.
- DONE: lasts exactly one cycle with done=1. Next edge returns to IDLE with done=0.
  - If start=1 on that edge, the new operands are captured and the block goes directly to SHIFT (back-to-back, no idle cycle).
- Latency: start accepted at edge k -> done=1 and results valid after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- Diff_out/Bor_out hold their last values through IDLE and the next SHIFT until the next completion. They never show partial results.
- busy and done are never high together.
- Arithmetic identity at completion: {Bor_out, Diff_out} = ({1'b0,A} - {1'b0,B} - Bor_in) taken as a (WIDTH+1)-bit two's complement, with Bor_out = its MSB.
- A change of A/B/Bor_in after capture has no effect on the result in progress.

Test Plan:
- Reset then A=9, B=3, Bor_in=0, start pulse -> done exactly 4 cycles after the start edge; Diff_out=6, Bor_out=0; busy high for 4 cycles.
- Borrow wrap cases: A=5, B=7, Bor_in=1 -> Diff_out=13, Bor_out=1. A=0, B=0, Bor_in=1 -> Diff_out=15, Bor_out=1. A=15, B=15, Bor_in=0 -> Diff_out=0, Bor_out=0.
- Start held/re-pulsed during SHIFT: A=8, B=2 accepted, then start with A=1, B=1 on cycle 2 -> result Diff_out=6; only one done pulse.
- Back-to-back: start asserted in the DONE cycle with A=14, B=1, Bor_in=1 -> busy rises on the next edge; second done 4 cycles later with Diff_out=12, Bor_out=0.
- Reset mid-op: drop rst_n asynchronously 2 cycles into SHIFT -> all outputs 0 immediately, state IDLE, no done. A fresh op (A=11, B=10, Bor_in=0) then gives Diff_out=1.
- WIDTH=8 instance: A=200, B=100, Bor_in=1 -> done 8 cycles after start; Diff_out=99, Bor_out=0. Exhaustive 4-bit sweep against the reference arithmetic identity.
